// File: rtl/fbuf_scanout.sv
// VGA-style scanout: walks the raster, reads the framebuffer with pixel
// replication, and emits colour plus sync/de aligned to the same raster position.
module fbuf_scanout #(
  parameter int FRAME_WIDTH     = 160,
  parameter int FRAME_HEIGHT    = 120,
  parameter int SCALING_FACTOR  = 4,
  parameter int FBUF_ADDR_WIDTH = 16,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_rd_address,
  output logic                       fbuf_rd_en,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
  output logic [FBUF_DATA_WIDTH-1:0] pixel_color,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic                       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int SHIFT   = $clog2(SCALING_FACTOR);

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_C = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] H_SS    = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SE    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_SS    = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SE    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] FW_C = FBUF_ADDR_WIDTH'(FRAME_WIDTH);

  if (SCALING_FACTOR < 1 || (SCALING_FACTOR & (SCALING_FACTOR - 1)) != 0) begin : g_bad_scale
    $error("fbuf_scanout: SCALING_FACTOR must be a power of two");
  end
  if (longint'(FRAME_WIDTH) * longint'(FRAME_HEIGHT) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_bad_aw
    $error("fbuf_scanout: framebuffer does not fit FBUF_ADDR_WIDTH");
  end
  if (H_ACTIVE != FRAME_WIDTH * SCALING_FACTOR || V_ACTIVE != FRAME_HEIGHT * SCALING_FACTOR) begin : g_bad_geom
    $error("fbuf_scanout: active area must equal frame size times SCALING_FACTOR");
  end

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic                       active;
  logic                       hs_on;
  logic                       vs_on;
  logic                       first_px;
  logic [FBUF_ADDR_WIDTH-1:0] row_idx;
  logic [FBUF_ADDR_WIDTH-1:0] col_idx;
  logic [FBUF_ADDR_WIDTH-1:0] addr_next;

  // Replication falls out of the shifts: the address only changes every
  // SCALING_FACTOR pixels and every SCALING_FACTOR lines.
  always_comb begin
    active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_on     = (h_cnt >= H_SS) && (h_cnt <= H_SE);
    vs_on     = (v_cnt >= V_SS) && (v_cnt <= V_SE);
    first_px  = (h_cnt == '0) && (v_cnt == '0);
    row_idx   = FBUF_ADDR_WIDTH'(v_cnt >> SHIFT);
    col_idx   = FBUF_ADDR_WIDTH'(h_cnt >> SHIFT);
    addr_next = active ? (row_idx * FW_C + col_idx) : '0;
  end

  // Read port contract: no handshake. Data is taken exactly one cycle after
  // fbuf_rd_en and ignored whenever the enable was low.
  logic s0_de, s0_hs, s0_vs, s0_fs;
  logic s1_de, s1_hs, s1_vs, s1_fs;

  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_rd_en      <= 1'b0;
      fbuf_rd_address <= '0;
      s0_de <= 1'b0; s0_hs <= 1'b0; s0_vs <= 1'b0; s0_fs <= 1'b0;
      s1_de <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0; s1_fs <= 1'b0;
      pixel_color <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      fbuf_rd_en      <= active;
      fbuf_rd_address <= addr_next;
      s0_de <= active; s0_hs <= hs_on; s0_vs <= vs_on; s0_fs <= first_px;
      s1_de <= s0_de;  s1_hs <= s0_hs; s1_vs <= s0_vs; s1_fs <= s0_fs;
      pixel_color <= s1_de ? fbuf_rd_data : '0;
      hsync       <= ~s1_hs;
      vsync       <= ~s1_vs;
      de          <= s1_de;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_fbuf_scanout.sv
// Bench for fbuf_scanout: a default-geometry instance and a shrunken instance
// (full frames within a short run), both checked cycle by cycle against a raster model.
module tb_fbuf_scanout;

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
    logic [7:0]  pix;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
  } obs_t;

  typedef struct {
    int fw; int s;
    int ha; int hfp; int hsy; int hbp;
    int va; int vfp; int vsy; int vbp;
  } geom_t;

  typedef struct {
    int   t;
    obs_t o;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int t_cyc = 0;
  always @(posedge clk) t_cyc <= rst ? 0 : t_cyc + 1;

  // ---------------- DUTs and framebuffer models ----------------
  logic [15:0] d_rd_address; logic d_rd_en; logic [7:0] d_rd_data;
  logic [7:0]  d_pixel_color; logic d_hsync, d_vsync, d_de, d_frame_start;
  logic [6:0]  s_rd_address; logic s_rd_en; logic [7:0] s_rd_data;
  logic [7:0]  s_pixel_color; logic s_hsync, s_vsync, s_de, s_frame_start;

  fbuf_scanout u_dut (
    .clk(clk), .rst(rst),
    .fbuf_rd_address(d_rd_address), .fbuf_rd_en(d_rd_en), .fbuf_rd_data(d_rd_data),
    .pixel_color(d_pixel_color), .hsync(d_hsync), .vsync(d_vsync),
    .de(d_de), .frame_start(d_frame_start)
  );

  fbuf_scanout #(
    .FRAME_WIDTH(16), .FRAME_HEIGHT(8), .SCALING_FACTOR(4),
    .FBUF_ADDR_WIDTH(7), .FBUF_DATA_WIDTH(8),
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .rst(rst),
    .fbuf_rd_address(s_rd_address), .fbuf_rd_en(s_rd_en), .fbuf_rd_data(s_rd_data),
    .pixel_color(s_pixel_color), .hsync(s_hsync), .vsync(s_vsync),
    .de(s_de), .frame_start(s_frame_start)
  );

  logic [7:0] mem [0:19199];
  bit aa_mode = 1'b0;

  // Unrequested read cycles return noise so stray use of the data bus shows up.
  always @(posedge clk) begin
    d_rd_data <= d_rd_en ? (aa_mode ? 8'hAA : mem[d_rd_address]) : 8'($urandom);
    s_rd_data <= s_rd_en ? (aa_mode ? 8'hAA : mem[s_rd_address]) : 8'($urandom);
  end

  // ---------------- reference model ----------------
  geom_t g_def, g_small;

  function automatic obs_t model(input geom_t g, input int t);
    obs_t o;
    int htot, vtot, p, x, y;
    bit act;
    htot = g.ha + g.hfp + g.hsy + g.hbp;
    vtot = g.va + g.vfp + g.vsy + g.vbp;
    o = '{en: 1'b0, addr: 16'd0, pix: 8'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};
    if (t >= 1) begin
      p = t - 1; x = p % htot; y = (p / htot) % vtot;
      if (x < g.ha && y < g.va) begin
        o.en   = 1'b1;
        o.addr = 16'((y / g.s) * g.fw + x / g.s);
      end
    end
    if (t >= 3) begin
      p = t - 3; x = p % htot; y = (p / htot) % vtot;
      act  = (x < g.ha) && (y < g.va);
      o.de = act;
      o.hs = !(x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsy);
      o.vs = !(y >= g.va + g.vfp && y < g.va + g.vfp + g.vsy);
      o.fs = (x == 0) && (y == 0);
      if (act) o.pix = aa_mode ? 8'hAA : mem[(y / g.s) * g.fw + x / g.s];
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got en=%b addr=%0d pix=%02h hs=%b vs=%b de=%b fs=%b expected en=%b addr=%0d pix=%02h hs=%b vs=%b de=%b fs=%b",
               name, t_cyc, act.en, act.addr, act.pix, act.hs, act.vs, act.de, act.fs,
               exp.en, exp.addr, exp.pix, exp.hs, exp.vs, exp.de, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  vec_t vtab [14];
  bit   table_on = 1'b0;
  bit   stats_on = 1'b0;
  int   d_de_cnt, d_hs_cnt, s_fs_cnt, s_de_cnt, s_vs_cnt;

  function automatic vec_t mk(input int t, input logic en, input logic [15:0] addr,
                              input logic [7:0] pix, input logic hs, input logic vs,
                              input logic de, input logic fs);
    vec_t v;
    v.t = t;
    v.o = '{en: en, addr: addr, pix: pix, hs: hs, vs: vs, de: de, fs: fs};
    return v;
  endfunction

  task automatic run_cycles(input int n);
    obs_t d_obs, s_obs;
    repeat (n) begin
      @(negedge clk);
      d_obs = {d_rd_en, d_rd_address, d_pixel_color, d_hsync, d_vsync, d_de, d_frame_start};
      s_obs = {s_rd_en, 9'd0, s_rd_address, s_pixel_color, s_hsync, s_vsync, s_de, s_frame_start};
      check("model_default", d_obs, model(g_def, t_cyc));
      check("model_small", s_obs, model(g_small, t_cyc));
      if (table_on) begin
        for (int i = 0; i < 14; i++)
          if (vtab[i].t == t_cyc) check($sformatf("vec%0d", i), d_obs, vtab[i].o);
      end
      if (stats_on) begin
        if (t_cyc >= 3 && t_cyc < 803) begin
          d_de_cnt += int'(d_de);
          d_hs_cnt += int'(!d_hsync);
        end
        if (t_cyc >= 3 && t_cyc < 3123) begin
          s_fs_cnt += int'(s_frame_start);
          s_de_cnt += int'(s_de);
          s_vs_cnt += int'(!s_vsync);
        end
      end
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    run_cycles(n);
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    g_def   = '{fw: 160, s: 4, ha: 640, hfp: 16, hsy: 96, hbp: 48, va: 480, vfp: 10, vsy: 2, vbp: 33};
    g_small = '{fw: 16,  s: 4, ha: 64,  hfp: 4,  hsy: 8,  hbp: 4,  va: 32,  vfp: 2,  vsy: 2, vbp: 3};
    for (int i = 0; i < 19200; i++) mem[i] = 8'(i);

    //             t     en    addr    pix   hs vs de fs
    vtab[0]  = mk(0,    1'b0, 16'd0,   8'd0,   1, 1, 0, 0);
    vtab[1]  = mk(1,    1'b1, 16'd0,   8'd0,   1, 1, 0, 0);
    vtab[2]  = mk(3,    1'b1, 16'd0,   8'd0,   1, 1, 1, 1);
    vtab[3]  = mk(4,    1'b1, 16'd0,   8'd0,   1, 1, 1, 0);
    vtab[4]  = mk(5,    1'b1, 16'd1,   8'd0,   1, 1, 1, 0);
    vtab[5]  = mk(8,    1'b1, 16'd1,   8'd1,   1, 1, 1, 0);
    vtab[6]  = mk(9,    1'b1, 16'd2,   8'd1,   1, 1, 1, 0);
    vtab[7]  = mk(641,  1'b0, 16'd0,   8'd159, 1, 1, 1, 0);
    vtab[8]  = mk(643,  1'b0, 16'd0,   8'd0,   1, 1, 0, 0);
    vtab[9]  = mk(659,  1'b0, 16'd0,   8'd0,   0, 1, 0, 0);
    vtab[10] = mk(754,  1'b0, 16'd0,   8'd0,   0, 1, 0, 0);
    vtab[11] = mk(755,  1'b0, 16'd0,   8'd0,   1, 1, 0, 0);
    vtab[12] = mk(803,  1'b1, 16'd0,   8'd0,   1, 1, 1, 0);
    vtab[13] = mk(3207, 1'b1, 16'd161, 8'd161, 1, 1, 1, 0);

    // Address-pattern framebuffer: table vectors plus line/frame statistics.
    d_de_cnt = 0; d_hs_cnt = 0; s_fs_cnt = 0; s_de_cnt = 0; s_vs_cnt = 0;
    pulse_reset(3);
    table_on = 1'b1;
    stats_on = 1'b1;
    run_cycles(6300);
    table_on = 1'b0;
    stats_on = 1'b0;
    check_int("line_de_cycles", d_de_cnt, 640);
    check_int("line_hsync_low", d_hs_cnt, 96);
    check_int("small_frame_starts", s_fs_cnt, 1);
    check_int("small_frame_de", s_de_cnt, 64 * 32);
    check_int("small_vsync_low", s_vs_cnt, 2 * 80);

    // Random framebuffer contents with resets dropped at random raster positions.
    rst = 1'b1;
    for (int i = 0; i < 19200; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 4; r++) begin
      pulse_reset($urandom_range(1, 3));
      run_cycles($urandom_range(200, 3000));
    end

    // Constant bus value: colour must track de exactly.
    rst = 1'b1;
    aa_mode = 1'b1;
    pulse_reset(1);
    run_cycles(1700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
